// File: rtl/fmps_packet_capture.sv
// FMPS packet capture stage.
// Collects indexed FMPS packets during an acquisition interval into a buffer,
// tracks which indices have arrived, and publishes a status word whose
// active/valid edges start the downstream readout. A registered random-access
// read port lets the readout streamer scan the buffer.
module fmps_packet_capture #(
    parameter int INDEX_WIDTH   = 5,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                          sysClk,
    input  logic                          sysReset,
    input  logic                          acqStart,
    input  logic [TIMEOUT_WIDTH-1:0]      acqTimeout,
    input  logic [(1<<INDEX_WIDTH)-1:0]   expectedBitmap,
    input  logic                          pktValid,
    input  logic [INDEX_WIDTH-1:0]        pktIndex,
    input  logic [31:0]                   pktData,
    output logic [31:0]                   fmpsCSR,
    output logic [(1<<INDEX_WIDTH)-1:0]   fmpsBitmapAll,
    input  logic [INDEX_WIDTH-1:0]        fmpsReadoutAddress,
    output logic [31:0]                   fmpsReadout
);

    localparam int N  = 1 << INDEX_WIDTH;
    localparam int CW = INDEX_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                    state_r;
    logic                      active_r;
    logic                      valid_r;
    logic                      timeout_r;
    logic                      dup_r;
    logic                      stray_r;
    logic [CW-1:0]             count_r;
    logic [N-1:0]              bitmap_r;
    logic [TIMEOUT_WIDTH-1:0]  timer_r;
    logic [31:0]               readout_r;
    logic [31:0]               ram_r [0:N-1];

    logic [N-1:0]              idx_onehot_s;
    logic [N-1:0]              bitmap_next_s;
    logic                      accept_s;
    logic                      dup_s;
    logic                      complete_s;
    logic                      expire_s;

    // Classify the incoming packet and evaluate completion/expiry on the
    // bitmap as it will look after this cycle's capture.
    always_comb begin
        idx_onehot_s  = {{(N-1){1'b0}}, 1'b1} << pktIndex;
        bitmap_next_s = bitmap_r;
        accept_s      = 1'b0;
        dup_s         = 1'b0;
        // A start pulse wins over a packet in the same cycle: the packet is dropped.
        if ((state_r == ST_ACTIVE) && !acqStart && pktValid) begin
            if ((bitmap_r & idx_onehot_s) == '0) begin
                accept_s      = 1'b1;
                bitmap_next_s = bitmap_r | idx_onehot_s;
            end else begin
                dup_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
        complete_s = (state_r == ST_ACTIVE) && !acqStart && (expectedBitmap != '0) &&
                     ((bitmap_next_s & expectedBitmap) == expectedBitmap);
        // Timer only runs when it was loaded non-zero; reaching 0 ends the interval.
        expire_s   = (state_r == ST_ACTIVE) && !acqStart &&
                     (timer_r == TIMEOUT_WIDTH'(1));
    end

    // Acquisition control FSM with all status fields held in registers.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state_r   <= ST_IDLE;
            active_r  <= 1'b0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            dup_r     <= 1'b0;
            stray_r   <= 1'b0;
            count_r   <= '0;
            bitmap_r  <= '0;
            timer_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acqStart) begin
                        state_r   <= ST_ACTIVE;
                        active_r  <= 1'b1;
                        valid_r   <= 1'b0;
                        timeout_r <= 1'b0;
                        dup_r     <= 1'b0;
                        count_r   <= '0;
                        bitmap_r  <= '0;
                        timer_r   <= acqTimeout;
                    end else if (pktValid) begin
                        stray_r <= 1'b1;
                    end else begin
                        stray_r <= stray_r;
                    end
                end
                ST_ACTIVE: begin
                    if (acqStart) begin
                        // Restart: identical clearing to a fresh start; stray persists.
                        active_r  <= 1'b1;
                        valid_r   <= 1'b0;
                        timeout_r <= 1'b0;
                        dup_r     <= 1'b0;
                        count_r   <= '0;
                        bitmap_r  <= '0;
                        timer_r   <= acqTimeout;
                    end else begin
                        if (accept_s) begin
                            bitmap_r <= bitmap_next_s;
                            count_r  <= count_r + CW'(1);
                        end else if (dup_s) begin
                            dup_r <= 1'b1;
                        end else begin
                            dup_r <= dup_r;
                        end
                        if (timer_r != '0) begin
                            timer_r <= timer_r - TIMEOUT_WIDTH'(1);
                        end else begin
                            timer_r <= timer_r;
                        end
                        // Completion beats timeout when both land on the same edge.
                        if (complete_s) begin
                            valid_r  <= 1'b1;
                            active_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else if (expire_s) begin
                            timeout_r <= 1'b1;
                            active_r  <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            state_r <= ST_ACTIVE;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    // Capture buffer: first packet for an index wins; contents are never reset.
    always_ff @(posedge sysClk) begin
        if (accept_s) begin
            ram_r[pktIndex] <= pktData;
        end
    end

    // Registered read port; a same-cycle write to the address returns the old word.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            readout_r <= 32'h0000_0000;
        end else begin
            readout_r <= ram_r[fmpsReadoutAddress];
        end
    end

    assign fmpsCSR       = {active_r, valid_r, timeout_r, dup_r, stray_r,
                            {(32-5-CW){1'b0}}, count_r};
    assign fmpsBitmapAll = bitmap_r;
    assign fmpsReadout   = readout_r;

endmodule
